// File: rtl/lift_req_if.sv
// Hall-request bus between the button front end and the lift controller FSM.
// The q_level signal exists only when LIFT_QUEUE_LEVEL_EN is defined.
interface lift_req_if;
  logic [5:0] btn;
  logic       lift_done;
  logic [2:0] q_dout;
  logic       q_empty;
  logic       q_full;
`ifdef LIFT_QUEUE_LEVEL_EN
  logic [2:0] q_level;
`endif

  modport master (
    output btn,
    output lift_done,
    input  q_dout,
    input  q_empty,
`ifdef LIFT_QUEUE_LEVEL_EN
    input  q_level,
`endif
    input  q_full
  );

  modport slave (
    input  btn,
    input  lift_done,
    output q_dout,
    output q_empty,
`ifdef LIFT_QUEUE_LEVEL_EN
    output q_level,
`endif
    output q_full
  );
endinterface

// File: rtl/lift_req_queue.sv
// Hall-button request FIFO with duplicate suppression feeding the lift controller.
// Optional macro LIFT_QUEUE_LEVEL_EN exposes the registered entry count on q_level.
module lift_req_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  lift_req_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0]    count_q;
  logic [5:0]    waiting_q, queued_q, btn_q;

  logic [5:0]    press, accept, sel_oh, head_oh;
  logic [5:0]    waiting_d, queued_d;
  logic [2:0]    head_idx, sel_idx, count_d;
  logic          sel_vld, pop, push, empty, full;

  function automatic logic [2:0] idx2code(input logic [2:0] idx);
    case (idx)
      3'd0:    idx2code = 3'b001;
      3'd1:    idx2code = 3'b010;
      3'd2:    idx2code = 3'b011;
      3'd3:    idx2code = 3'b110;
      3'd4:    idx2code = 3'b111;
      3'd5:    idx2code = 3'b100;
      default: idx2code = 3'b000;
    endcase
  endfunction

  assign empty    = (count_q == 3'd0);
  assign full     = (count_q == 3'(DEPTH));
  assign head_idx = fifo_q[rd_ptr_q];
  assign head_oh  = 6'b000001 << head_idx;
  assign press    = bus.btn & ~btn_q;
  assign pop      = bus.lift_done & ~empty;

  // Lowest-index waiting button wins the single enqueue slot each cycle.
  always_comb begin
    sel_idx = 3'd0;
    sel_vld = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      if (waiting_q[k]) begin
        sel_idx = 3'(k);
        sel_vld = 1'b1;
      end
    end
  end

  assign sel_oh = 6'b000001 << sel_idx;
  assign push   = sel_vld & (~full | pop);

  // A press is taken only if that button is neither pending nor queued,
  // unless its queued copy is leaving on this very edge.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_accept
      assign accept[gi] = press[gi] & ~waiting_q[gi] &
                          (~queued_q[gi] | (pop & head_oh[gi]));
    end
  endgenerate

  assign waiting_d = (waiting_q & ~(push ? sel_oh : 6'b0)) | accept;
  assign queued_d  = (queued_q & ~(pop ? head_oh : 6'b0)) | (push ? sel_oh : 6'b0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) fifo_q[k] <= 3'd0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= 3'd0;
      waiting_q <= 6'd0;
      queued_q  <= 6'd0;
      btn_q     <= 6'd0;
    end else begin
      btn_q     <= bus.btn;
      waiting_q <= waiting_d;
      queued_q  <= queued_d;
      count_q   <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sel_idx;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
    end
  end

  assign bus.q_dout  = empty ? 3'b000 : idx2code(head_idx);
  assign bus.q_empty = empty;
  assign bus.q_full  = full;
`ifdef LIFT_QUEUE_LEVEL_EN
  assign bus.q_level = count_q;
`endif
endmodule

// File: tb/tb_lift_req_queue.sv
// Self-checking bench for lift_req_queue: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_lift_req_queue;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] btn;
  logic       lift_done;
  int         checks;
  int         errors;

  lift_req_if bus ();
  assign bus.btn       = btn;
  assign bus.lift_done = lift_done;

  lift_req_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pending-button set plus an ordered queue of button indices.
  int       mq[$];
  bit [5:0] m_wait;
  bit [5:0] m_prev;

  function automatic int code_of(input int idx);
    case (idx)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 6;
      4: return 7;
      5: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_queue(input int idx);
    foreach (mq[k]) if (mq[k] == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_dout();
    return (mq.size() > 0) ? code_of(mq[0]) : 0;
  endfunction

  task automatic model_step();
    bit [5:0] press;
    bit [5:0] acc;
    bit       pop;
    bit       push;
    int       head;
    int       sel;
    if (!rst_n) begin
      mq.delete();
      m_wait = '0;
      m_prev = '0;
      return;
    end
    press = btn & ~m_prev;
    pop   = lift_done && (mq.size() > 0);
    head  = pop ? mq[0] : -1;
    sel   = -1;
    for (int i = 0; i < 6; i++) if (m_wait[i] && sel < 0) sel = i;
    push  = (sel >= 0) && ((mq.size() < DEPTH) || pop);
    acc   = '0;
    for (int i = 0; i < 6; i++)
      if (press[i] && !m_wait[i] && (!in_queue(i) || head == i)) acc[i] = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(sel);
      m_wait[sel] = 1'b0;
    end
    m_wait = m_wait | acc;
    m_prev = btn;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_dout",  int'(bus.q_dout),  m_dout());
    chk("model_empty", int'(bus.q_empty), int'(mq.size() == 0));
    chk("model_full",  int'(bus.q_full),  int'(mq.size() == DEPTH));
`ifdef LIFT_QUEUE_LEVEL_EN
    chk("model_level", int'(bus.q_level), mq.size());
`endif
  endtask

  task automatic drive(input bit r, input bit [5:0] b, input bit l);
    rst_n     = r;
    btn       = b;
    lift_done = l;
    tick();
  endtask

  typedef struct {
    bit       rst_n;
    bit [5:0] btn;
    bit       ld;
    int       dout;
    bit       empty;
    bit       full;
    int       level;
  } vec_t;

  vec_t vecs[13];

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    btn       = 6'd0;
    lift_done = 1'b0;

    vecs[0]  = '{1'b0, 6'b000000, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b0, 6'b000000, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[2]  = '{1'b1, 6'b000010, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[3]  = '{1'b1, 6'b000000, 1'b0, 2, 1'b0, 1'b0, 1};
    vecs[4]  = '{1'b1, 6'b000000, 1'b1, 0, 1'b1, 1'b0, 0};
    vecs[5]  = '{1'b1, 6'b100101, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[6]  = '{1'b1, 6'b000000, 1'b0, 1, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b1, 6'b000000, 1'b0, 1, 1'b0, 1'b0, 2};
    vecs[8]  = '{1'b1, 6'b000000, 1'b0, 1, 1'b0, 1'b0, 3};
    vecs[9]  = '{1'b1, 6'b000000, 1'b1, 3, 1'b0, 1'b0, 2};
    vecs[10] = '{1'b1, 6'b000000, 1'b1, 4, 1'b0, 1'b0, 1};
    vecs[11] = '{1'b1, 6'b000000, 1'b1, 0, 1'b1, 1'b0, 0};
    vecs[12] = '{1'b1, 6'b000000, 1'b1, 0, 1'b1, 1'b0, 0};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst_n, vecs[i].btn, vecs[i].ld);
      chk("tbl_dout",  int'(bus.q_dout),  vecs[i].dout);
      chk("tbl_empty", int'(bus.q_empty), int'(vecs[i].empty));
      chk("tbl_full",  int'(bus.q_full),  int'(vecs[i].full));
`ifdef LIFT_QUEUE_LEVEL_EN
      chk("tbl_level", int'(bus.q_level), vecs[i].level);
`endif
      $display("vec %0d rst_n=%0b btn=%b ld=%0b -> dout=%b empty=%0b full=%0b",
               i, vecs[i].rst_n, vecs[i].btn, vecs[i].ld,
               bus.q_dout, bus.q_empty, bus.q_full);
    end

    // Duplicate suppression, then re-queue on the pop edge.
    drive(1'b1, 6'b001000, 1'b0);
    drive(1'b1, 6'b000000, 1'b0);
    chk("dup_first", int'(bus.q_dout), 6);
    drive(1'b1, 6'b001000, 1'b0);
    drive(1'b1, 6'b000000, 1'b0);
    drive(1'b1, 6'b000000, 1'b0);
    chk("dup_still", int'(bus.q_dout), 6);
    drive(1'b1, 6'b000000, 1'b1);
    chk("dup_single_pop", int'(bus.q_empty), 1);
    drive(1'b1, 6'b000000, 1'b0);
    chk("dup_no_second", int'(bus.q_empty), 1);
    drive(1'b1, 6'b001000, 1'b0);
    drive(1'b1, 6'b000000, 1'b0);
    drive(1'b1, 6'b001000, 1'b1);
    chk("requeue_popped", int'(bus.q_empty), 1);
    drive(1'b1, 6'b000000, 1'b0);
    chk("requeue_dout", int'(bus.q_dout), 6);
    drive(1'b1, 6'b000000, 1'b1);
    chk("requeue_drain", int'(bus.q_empty), 1);
    $display("seq duplicate done");

    // Full: five presses, four slots; the fifth enters on the first pop.
    drive(1'b1, 6'b011111, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 6'b000000, 1'b0);
    chk("full_set", int'(bus.q_full), 1);
    chk("full_head", int'(bus.q_dout), 1);
    drive(1'b1, 6'b000000, 1'b0);
    chk("full_hold", int'(bus.q_full), 1);
    drive(1'b1, 6'b000000, 1'b1);
    chk("full_poppush_full", int'(bus.q_full), 1);
    chk("full_poppush_head", int'(bus.q_dout), 2);
    drive(1'b1, 6'b000000, 1'b1);
    chk("full_drain1", int'(bus.q_dout), 3);
    chk("full_drop", int'(bus.q_full), 0);
    drive(1'b1, 6'b000000, 1'b1);
    chk("full_drain2", int'(bus.q_dout), 6);
    drive(1'b1, 6'b000000, 1'b1);
    chk("full_drain3", int'(bus.q_dout), 7);
    drive(1'b1, 6'b000000, 1'b1);
    chk("full_drain4", int'(bus.q_empty), 1);
    $display("seq full done");

    // Mid-operation reset discards queued entries.
    drive(1'b1, 6'b000111, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 6'b000000, 1'b0);
    chk("midrst_pre", int'(bus.q_dout), 1);
    drive(1'b0, 6'b000000, 1'b0);
    chk("midrst_empty", int'(bus.q_empty), 1);
    chk("midrst_dout", int'(bus.q_dout), 0);
    chk("midrst_full", int'(bus.q_full), 0);
`ifdef LIFT_QUEUE_LEVEL_EN
    chk("midrst_level", int'(bus.q_level), 0);
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b000000, 1'b0);
      chk("midrst_stale", int'(bus.q_empty), 1);
    end
    $display("seq midop reset done");

    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      btn       = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
      lift_done = ($urandom_range(0, 3) == 0);
      tick();
    end
    $display("random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
